// File: rtl/common_pkg.sv
// Shared helpers: the V(n) vector-width macro and elaboration-time parameter checks.
`ifndef COMMON_PKG_V_MACRO
`define COMMON_PKG_V_MACRO
`define V(n) [(n)-1:0]
`endif

package common_pkg;

  // True when a size parameter is strictly positive.
  function automatic bit check_param_pos(input int value);
    return value > 0;
  endfunction

endpackage

// File: rtl/queue_fifo.sv
// Show-ahead FIFO (W x N): head visible the cycle after the push, pop takes effect at the edge;
// i_rdy drops when full (full push dropped even with a same-cycle pop). Optional checks: QUEUE_FIFO_ASSERT_EN.
module queue_fifo
  import common_pkg::*;
#(
  parameter int W = 1,
  parameter int N = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        i_v,
  output logic        i_rdy,
  input  logic `V(W)  i,
  output logic        o_v,
  input  logic        o_rdy,
  output logic `V(W)  o
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] count_t;

  localparam ptr_t   LAST_PTR = ptr_t'(N - 1);
  localparam count_t FULL_CNT = count_t'(N);

  if (!check_param_pos(W)) begin : g_bad_w
    $error("queue_fifo: W must be at least 1");
  end
  if (!check_param_pos(N - 1)) begin : g_bad_n
    $error("queue_fifo: N must be at least 2");
  end

  logic `V(W) mem [N];
  ptr_t       rd_ptr;
  ptr_t       wr_ptr;
  count_t     count;
  logic       push;
  logic       pop;

  assign i_rdy = (count != FULL_CNT);
  assign o_v   = (count != '0);
  assign push  = i_v & i_rdy & clk_en;
  assign pop   = o_rdy & o_v & clk_en;
  assign o     = o_v ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i;
    end
  end

  // Wrap is explicit so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ptr_t'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + count_t'(1);
        2'b01:   count <= count - count_t'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef QUEUE_FIFO_ASSERT_EN
  always @(posedge clk) begin
    if (!rst && clk_en) begin
      if (i_v && !i_rdy) $error("queue_fifo: push while full");
      if (o_rdy && !o_v) $error("queue_fifo: pop while empty");
      if (count > FULL_CNT) $error("queue_fifo: count exceeds depth");
    end
  end
`endif

endmodule

// File: tb/tb_queue_fifo.sv
// Bench for queue_fifo (W=2, N=4): directed vector table, corner sequences, random run against a queue model.
module tb_queue_fifo;

  localparam int W = 2;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clk_en = 1'b0;
  logic         i_v = 1'b0;
  logic         i_rdy;
  logic [W-1:0] i = '0;
  logic         o_v;
  logic         o_rdy = 1'b0;
  logic [W-1:0] o;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model_q [$];

  queue_fifo #(.W(W), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .i_v    (i_v),
    .i_rdy  (i_rdy),
    .i      (i),
    .o_v    (o_v),
    .o_rdy  (o_rdy),
    .o      (o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         exp_ov;
    logic         exp_irdy;
    logic [W-1:0] exp_o;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic v, input logic [W-1:0] d,
                       input logic rd);
    rst = r; clk_en = en; i_v = v; i = d; o_rdy = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic en, input logic v, input int d, input logic rd,
                     input logic eov, input logic erdy, input int eo);
    vec_t t;
    t.rst = r; t.en = en; t.iv = v; t.id = W'(d); t.ordy = rd;
    t.exp_ov = eov; t.exp_irdy = erdy; t.exp_o = W'(eo);
    vecs.push_back(t);
  endtask

  // Model check: outputs must reflect the queue contents.
  task automatic chk_model(input string tag);
    chk({tag, ".o_v"}, int'(o_v), int'(model_q.size() != 0));
    chk({tag, ".i_rdy"}, int'(i_rdy), int'(model_q.size() != N));
    chk({tag, ".o"}, int'(o), (model_q.size() != 0) ? int'(model_q[0]) : 0);
  endtask

  initial begin
    // rst en iv d ordy | o_v i_rdy o  (outputs after the edge)
    add(1, 1, 0, 0, 0, 0, 1, 0);  // reset
    add(0, 1, 0, 0, 1, 0, 1, 0);  // pop while empty ignored
    add(0, 1, 1, 3, 0, 1, 1, 3);  // push 3: head visible next cycle
    add(0, 1, 1, 1, 0, 1, 1, 3);
    add(0, 1, 1, 2, 0, 1, 1, 3);
    add(0, 1, 0, 0, 1, 1, 1, 1);  // pop 3
    add(0, 1, 0, 0, 1, 1, 1, 2);  // pop 1
    add(0, 1, 0, 0, 1, 0, 1, 0);  // pop 2, empty
    add(0, 1, 1, 0, 0, 1, 1, 0);  // fill 0,1,2,3
    add(0, 1, 1, 1, 0, 1, 1, 0);
    add(0, 1, 1, 2, 0, 1, 1, 0);
    add(0, 1, 1, 3, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 0);  // push while full ignored
    add(0, 1, 1, 2, 1, 1, 1, 1);  // full push+pop: only pop
    add(0, 1, 1, 2, 0, 1, 0, 1);  // contents 1,2,3,2
    add(0, 1, 0, 0, 1, 1, 1, 2);
    add(0, 1, 0, 0, 1, 1, 1, 3);
    add(0, 1, 0, 0, 1, 1, 1, 2);
    add(0, 1, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1, 0);  // disabled push ignored
    add(0, 1, 1, 3, 0, 1, 1, 3);
    add(1, 0, 1, 2, 1, 0, 1, 0);  // reset wins over clk_en=0

    step();
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].en, vecs[k].iv, vecs[k].id, vecs[k].ordy);
      step();
      chk($sformatf("vec%0d.o_v", k), int'(o_v), int'(vecs[k].exp_ov));
      chk($sformatf("vec%0d.i_rdy", k), int'(i_rdy), int'(vecs[k].exp_irdy));
      chk($sformatf("vec%0d.o", k), int'(o), int'(vecs[k].exp_o));
    end

    // clk_en low with both requests for 5 cycles: two entries must stay put.
    drive(0, 1, 1, 2, 0); step();
    drive(0, 1, 1, 1, 0); step();
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1, 3, 1);
      step();
      chk($sformatf("hold%0d.o_v", c), int'(o_v), 1);
      chk($sformatf("hold%0d.o", c), int'(o), 2);
      chk($sformatf("hold%0d.i_rdy", c), int'(i_rdy), 1);
    end
    drive(0, 1, 0, 0, 1); step();
    chk("hold_pop1.o", int'(o), 1);

    // Reset with three entries held.
    drive(0, 1, 1, 3, 0); step();
    drive(0, 1, 1, 0, 0); step();
    chk("pre_rst.i_rdy", int'(i_rdy), 1);
    drive(1, 1, 0, 0, 0); step();
    chk("rst3.o_v", int'(o_v), 0);
    chk("rst3.i_rdy", int'(i_rdy), 1);
    chk("rst3.o", int'(o), 0);
    drive(0, 1, 0, 0, 0); step();
    model_q.delete();

    // Half-full streaming over 2N cycles with pointer wrap.
    for (int c = 0; c < 2; c++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      drive(0, 1, 1, d, 0); step();
      model_q.push_back(d);
    end
    for (int c = 0; c < 2 * N; c++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      chk($sformatf("stream%0d.head", c), int'(o), int'(model_q[0]));
      drive(0, 1, 1, d, 1); step();
      void'(model_q.pop_front());
      model_q.push_back(d);
      chk_model($sformatf("stream%0d", c));
    end

    // Randomized traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      logic r, en, v, rd;
      logic [W-1:0] d;
      bit do_push, do_pop;
      r  = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      d  = W'($urandom);
      do_push = v && en && (model_q.size() < N);
      do_pop  = rd && en && (model_q.size() > 0);
      drive(r, en, v, d, rd);
      step();
      if (r) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
      end
      chk_model($sformatf("rnd%0d", c));
    end

    drive(0, 0, 0, 0, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
